// File: rtl/rv_alu_pkg.sv
// Shared widths and operation codes for the RV32I execute-stage ALU.
package rv_alu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 4;

    // funct_alu = {funct7[5], funct3}; bit 3 is a don't-care except for ADD/SUB and SRL/SRA
    localparam logic [FUNCT_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [FUNCT_W-1:0] ALU_SUB = 4'b1000;
    localparam logic [FUNCT_W-1:0] ALU_SLL = 4'b0001;
    localparam logic [FUNCT_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [FUNCT_W-1:0] ALU_SRA = 4'b1101;
    localparam logic [FUNCT_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [FUNCT_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [FUNCT_W-1:0] ALU_AND = 4'b0111;

endpackage

// File: rtl/alu_shifter.sv
// Log-stage barrel shifter serving SLL, SRL and SRA.
module alu_shifter
    import rv_alu_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               left,
    input  logic               arith,
    output logic [XLEN-1:0]    result_c
);

    logic              fill;
    logic [XLEN-1:0]   stage [SHAMT_W+1];

    assign fill     = arith & data[XLEN-1];
    assign stage[0] = data;

    // Stage i shifts by 2**i when shamt[i] is set.
    for (genvar i = 0; i < int'(SHAMT_W); i++) begin : g_stage
        localparam int unsigned S = 1 << i;
        logic [XLEN-1:0] shl;
        logic [XLEN-1:0] shr;

        assign shl = {stage[i][XLEN-S-1:0], {S{1'b0}}};
        assign shr = {{S{fill}}, stage[i][XLEN-1:S]};
        assign stage[i+1] = shamt[i] ? (left ? shl : shr) : stage[i];
    end

    assign result_c = stage[SHAMT_W];

endmodule

// File: rtl/rv_alu.sv
// RV32I integer ALU: combinational result plus a registered copy for the pipeline.
module rv_alu
    import rv_alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    aluin1,
    input  logic [XLEN-1:0]    aluin2,
    input  logic [FUNCT_W-1:0] funct_alu,
    output logic [XLEN-1:0]    aluout,
    output logic [XLEN-1:0]    aluout_q
);

    logic            sub;
    logic            arith;
    logic            left;
    logic [XLEN-1:0] add_sub;
    logic [XLEN-1:0] shift_res;

    assign sub   = (funct_alu == ALU_SUB);
    assign arith = (funct_alu == ALU_SRA);
    assign left  = (funct_alu[2:0] == ALU_SLL[2:0]);

    // Two's-complement subtract shares the adder: invert B and inject the carry.
    assign add_sub = aluin1 + (aluin2 ^ {XLEN{sub}}) + XLEN'(sub);

    alu_shifter u_shifter (
        .data     (aluin1),
        .shamt    (aluin2[SHAMT_W-1:0]),
        .left     (left),
        .arith    (arith),
        .result_c (shift_res)
    );

    // Reserved SLT/SLTU slots are a deliberate don't-care.
    always_comb begin
        aluout = 'x;
        case (funct_alu[2:0])
            ALU_ADD[2:0]: aluout = add_sub;
            ALU_SLL[2:0]: aluout = shift_res;
            ALU_SRL[2:0]: aluout = shift_res;
            ALU_XOR[2:0]: aluout = aluin1 ^ aluin2;
            ALU_OR[2:0]:  aluout = aluin1 | aluin2;
            ALU_AND[2:0]: aluout = aluin1 & aluin2;
            default:      aluout = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_q <= '0;
        end else begin
            aluout_q <= aluout;
        end
    end

endmodule

// File: tb/tb_rv_alu.sv
// Directed and short random checks for rv_alu, combinational and registered outputs.
module tb_rv_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [3:0]  funct_alu;
    logic [31:0] aluout;
    logic [31:0] aluout_q;

    int tests_run;
    int tests_failed;

    rv_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .aluin1    (aluin1),
        .aluin2    (aluin2),
        .funct_alu (funct_alu),
        .aluout    (aluout),
        .aluout_q  (aluout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        logic [4:0] sh;
        sh = b[4:0];
        case (f[2:0])
            3'b000:  ref_alu = f[3] ? a - b : a + b;
            3'b001:  ref_alu = a << sh;
            3'b101:  ref_alu = f[3] ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'b100:  ref_alu = a ^ b;
            3'b110:  ref_alu = a | b;
            3'b111:  ref_alu = a & b;
            default: ref_alu = 32'h0;
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b1;
        aluin1 = 32'h17; aluin2 = 32'h0A; funct_alu = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (aluout_q !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: aluout_q=%h expected=%h", aluout_q, 32'h0);
        end
        @(posedge clk); #1;
        tests_run++;
        if (aluout_q !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_held: aluout_q=%h expected=%h", aluout_q, 32'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (aluout_q !== 32'h21) begin
            tests_failed++;
            $display("FAIL reset_release: aluout_q=%h expected=%h", aluout_q, 32'h21);
        end
    endtask

    task automatic test_arith_logic;
        logic [3:0]  codes [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0100,
                                    4'b1100, 4'b0110, 4'b1110, 4'b0111, 4'b1111};
        logic [31:0] exps  [10] = '{32'h21, 32'h0D, 32'h5C00, 32'h5C00, 32'h1D,
                                    32'h1D, 32'h1F, 32'h1F, 32'h02, 32'h02};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            aluin1 = 32'h17; aluin2 = 32'h0A; funct_alu = codes[i];
            #1;
            tests_run++;
            if (aluout !== exps[i]) begin
                tests_failed++;
                $display("FAIL op_%b: aluout=%h expected=%h", codes[i], aluout, exps[i]);
            end
        end
    endtask

    task automatic test_right_shift;
        @(negedge clk);
        aluin1 = 32'h80000015; aluin2 = 32'h3; funct_alu = 4'b0101;
        #1;
        tests_run++;
        if (aluout !== 32'h10000002) begin
            tests_failed++;
            $display("FAIL srl: aluout=%h expected=%h", aluout, 32'h10000002);
        end
        funct_alu = 4'b1101;
        #1;
        tests_run++;
        if (aluout !== 32'hF0000002) begin
            tests_failed++;
            $display("FAIL sra: aluout=%h expected=%h", aluout, 32'hF0000002);
        end
    endtask

    task automatic test_reserved;
        logic [31:0] x_ref;
        logic [3:0]  codes [2] = '{4'b0011, 4'b0010};
        x_ref = 'x;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            aluin1 = 32'h17; aluin2 = 32'h0A; funct_alu = codes[i];
            #1;
            // Only meaningful where the simulator keeps four-state values.
            if ($isunknown(x_ref)) begin
                tests_run++;
                if (aluout !== x_ref) begin
                    tests_failed++;
                    $display("FAIL reserved_%b: aluout=%h expected=all-X", codes[i], aluout);
                end
            end
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] a_t [8] = '{32'hFFFFFFFF, 32'h0, 32'h17, 32'h80000000,
                                 32'h80000000, 32'h1, 32'h80000015, 32'h80000015};
        logic [31:0] b_t [8] = '{32'h1, 32'h1, 32'h25, 32'd31,
                                 32'd31, 32'd31, 32'h0, 32'h20};
        logic [3:0]  f_t [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b1101,
                                 4'b0101, 4'b1001, 4'b1101, 4'b0101};
        logic [31:0] e_t [8] = '{32'h0, 32'hFFFFFFFF, 32'h2E0, 32'hFFFFFFFF,
                                 32'h1, 32'h80000000, 32'h80000015, 32'h80000015};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            aluin1 = a_t[i]; aluin2 = b_t[i]; funct_alu = f_t[i];
            #1;
            tests_run++;
            if (aluout !== e_t[i]) begin
                tests_failed++;
                $display("FAIL boundary_%0d: aluout=%h expected=%h", i, aluout, e_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  valid [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101,
                                   4'b1101, 4'b0100, 4'b0110, 4'b1111};
        logic [31:0] exp_q;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            aluin1    = $urandom;
            aluin2    = $urandom;
            funct_alu = valid[$urandom_range(7, 0)];
            exp_q     = ref_alu(aluin1, aluin2, funct_alu);
            @(posedge clk); #1;
            tests_run++;
            if (aluout_q !== exp_q) begin
                tests_failed++;
                $display("FAIL pipe_%0d: aluout_q=%h expected=%h", i, aluout_q, exp_q);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        aluin1 = 32'h17; aluin2 = 32'h0A; funct_alu = 4'b0110;
        @(posedge clk); #1;
        tests_run++;
        if (aluout_q !== 32'h1F) begin
            tests_failed++;
            $display("FAIL mid_pre: aluout_q=%h expected=%h", aluout_q, 32'h1F);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (aluout_q !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: aluout_q=%h expected=%h", aluout_q, 32'h0);
        end
        tests_run++;
        if (aluout !== 32'h1F) begin
            tests_failed++;
            $display("FAIL mid_comb: aluout=%h expected=%h", aluout, 32'h1F);
        end
        @(negedge clk) rst_n = 1'b1;
        funct_alu = 4'b1000;
        @(posedge clk); #1;
        tests_run++;
        if (aluout_q !== 32'h0D) begin
            tests_failed++;
            $display("FAIL mid_resume: aluout_q=%h expected=%h", aluout_q, 32'h0D);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_arith_logic();
        test_right_shift();
        test_reserved();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
